// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: operation codes,
// FSM states and the default iteration count.
package muldiv_pkg;

    localparam int ITER = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10
    } state_e;

    function automatic logic op_is_div(input op_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input op_e op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/sign_fix.sv
// Combinational result correction: turns the unsigned magnitude result of the
// iteration into architectural {HI, LO}, including the divide-by-zero override.
module sign_fix
    import muldiv_pkg::*;
#(
    parameter int WIDTH = ITER
)
(
    input  logic [2*WIDTH-1:0] i_raw,
    input  logic               i_sign_a,
    input  logic               i_sign_b,
    input  op_e                i_op,
    input  logic               i_bzero,
    output logic [WIDTH-1:0]   o_hi,
    output logic [WIDTH-1:0]   o_lo
);

    logic                 w_neg;
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH-1:0]     w_quot;
    logic [WIDTH-1:0]     w_rem;

    assign w_neg  = i_sign_a ^ i_sign_b;
    assign w_prod = w_neg ? -i_raw : i_raw;
    assign w_quot = w_neg ? -i_raw[WIDTH-1:0] : i_raw[WIDTH-1:0];
    // Remainder follows the dividend's sign; with B=0 this reproduces A exactly.
    assign w_rem  = i_sign_a ? -i_raw[2*WIDTH-1:WIDTH] : i_raw[2*WIDTH-1:WIDTH];

    always_comb begin
        o_hi = w_prod[2*WIDTH-1:WIDTH];
        o_lo = w_prod[WIDTH-1:0];
        if (op_is_div(i_op)) begin
            o_hi = w_rem;
            o_lo = i_bzero ? '1 : w_quot;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO and MTHI/MTLO.
// One result bit per CALC cycle over magnitudes, signs applied in FIX.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = ITER
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int             CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_e               r_state;
    op_e                  r_op;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic                 r_sa;
    logic                 r_sb;
    logic                 r_bz;
    logic [2*WIDTH-1:0]   r_acc;
    logic [CW-1:0]        r_cnt;
    logic                 r_busy;
    logic                 r_done;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;

    op_e                  w_op;
    logic                 w_sa;
    logic                 w_sb;
    logic [WIDTH-1:0]     w_amag;
    logic [WIDTH-1:0]     w_bmag;
    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_mul_next;
    logic [WIDTH:0]       w_div_sh;
    logic                 w_div_ge;
    logic [WIDTH:0]       w_div_rem;
    logic [2*WIDTH-1:0]   w_div_next;
    logic [WIDTH-1:0]     w_fix_hi;
    logic [WIDTH-1:0]     w_fix_lo;

    // Launch-time operand conditioning
    assign w_op   = op_e'(op);
    assign w_sa   = op_is_signed(w_op) & A[WIDTH-1];
    assign w_sb   = op_is_signed(w_op) & B[WIDTH-1];
    assign w_amag = w_sa ? -A : A;
    assign w_bmag = w_sb ? -B : B;

    // Shift-add: multiplier sits in the low half and is consumed LSB first.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Restoring divide: quotient bits enter at the bottom as dividend bits leave the top.
    assign w_div_sh   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_div_ge   = (w_div_sh >= {1'b0, r_b});
    assign w_div_rem  = w_div_ge ? (w_div_sh - {1'b0, r_b}) : w_div_sh;
    assign w_div_next = {w_div_rem[WIDTH-1:0], r_acc[WIDTH-2:0], w_div_ge};

    sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .i_raw    (r_acc),
        .i_sign_a (r_sa),
        .i_sign_b (r_sb),
        .i_op     (r_op),
        .i_bzero  (r_bz),
        .o_hi     (w_fix_hi),
        .o_lo     (w_fix_lo)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_op    <= OP_MULT;
            r_a     <= '0;
            r_b     <= '0;
            r_sa    <= 1'b0;
            r_sb    <= 1'b0;
            r_bz    <= 1'b0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (mthi) r_hi <= wdata;
                    if (mtlo) r_lo <= wdata;
                    if (start) begin
                        r_op    <= w_op;
                        r_a     <= w_amag;
                        r_b     <= w_bmag;
                        r_sa    <= w_sa;
                        r_sb    <= w_sb;
                        r_bz    <= (B == '0);
                        r_acc   <= op_is_div(w_op) ? {{WIDTH{1'b0}}, w_amag}
                                                   : {{WIDTH{1'b0}}, w_bmag};
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_acc <= op_is_div(r_op) ? w_div_next : w_mul_next;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == LAST) r_state <= S_FIX;
                end
                S_FIX: begin
                    r_hi    <= w_fix_hi;
                    r_lo    <= w_fix_lo;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed table, multi-cycle corner
// sequences, and randomized operations against an arithmetic reference model.
module tb_muldiv_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t tbl[12];

    muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // MIPS semantics from plain integer arithmetic
    function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] h, output logic [31:0] l);
        int          sa;
        int          sb;
        longint      ps;
        logic [63:0] pu;
        sa = int'(a);
        sb = int'(b);
        case (o)
            2'b00: begin ps = longint'(sa) * longint'(sb); pu = 64'(ps); {h, l} = pu; end
            2'b01: begin pu = 64'(a) * 64'(b); {h, l} = pu; end
            default: begin
                if (b == 32'd0) begin
                    l = 32'hFFFF_FFFF; h = a;
                end else if (o == 2'b10 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    l = 32'h8000_0000; h = 32'd0;
                end else if (o == 2'b10) begin
                    l = 32'(sa / sb); h = 32'(sa % sb);
                end else begin
                    l = a / b; h = a % b;
                end
            end
        endcase
    endfunction

    // Entered at a negedge; returns at the negedge where done is seen (or on timeout).
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int nbusy, output bit held);
        logic [31:0] h0;
        logic [31:0] l0;
        h0 = hi;
        l0 = lo;
        op = o; A = a; B = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0; nbusy = 0; held = 1'b1;
        while (!done && lat < 60) begin
            if (busy) nbusy++;
            if (hi !== h0 || lo !== l0) held = 1'b0;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic count_dones(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done) n++;
        end
    endtask

    initial begin
        int          lat;
        int          nb;
        int          nd;
        bit          held;
        logic [31:0] eh;
        logic [31:0] el;
        logic [31:0] l0;

        tbl[0]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        tbl[1]  = '{2'b00, 32'hFFFF_FFF9, 32'h0000_0006, 32'hFFFF_FFFF, 32'hFFFF_FFD6};
        tbl[2]  = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        tbl[3]  = '{2'b11, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF};
        tbl[4]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        tbl[5]  = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
        tbl[6]  = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        tbl[7]  = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        tbl[8]  = '{2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        tbl[9]  = '{2'b11, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF};
        tbl[10] = '{2'b11, 32'd100,       32'd7,         32'd2,         32'd14};
        tbl[11] = '{2'b00, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};

        reset = 1'b1; start = 1'b0; op = 2'b00; A = '0; B = '0;
        mthi = 1'b0; mtlo = 1'b0; wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Directed table
        for (int i = 0; i < 12; i++) begin
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, lat, nb, held);
            check($sformatf("tbl%0d_lat", i), 64'(lat), 64'd33);
            check($sformatf("tbl%0d_busycyc", i), 64'(nb), 64'd33);
            check($sformatf("tbl%0d_hold", i), 64'(held), 64'd1);
            check($sformatf("tbl%0d_busy_at_done", i), 64'(busy), 64'd0);
            check($sformatf("tbl%0d_hi", i), 64'(hi), 64'(tbl[i].hi));
            check($sformatf("tbl%0d_lo", i), 64'(lo), 64'(tbl[i].lo));
            @(negedge clk);
            check($sformatf("tbl%0d_done_pulse", i), 64'(done), 64'd0);
        end

        // Back-to-back: launch in the done cycle
        run_op(2'b01, 32'd9, 32'd9, lat, nb, held);
        check("b2b_first_lo", 64'(lo), 64'd81);
        run_op(2'b11, 32'd81, 32'd4, lat, nb, held);
        check("b2b_lat", 64'(lat), 64'd33);
        check("b2b_hi", 64'(hi), 64'd1);
        check("b2b_lo", 64'(lo), 64'd20);
        @(negedge clk);

        // Second start mid-operation is ignored
        op = 2'b10; A = 32'h8000_0000; B = 32'hFFFF_FFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        op = 2'b01; A = 32'd3; B = 32'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat);
        check("ovf_lat", 64'(lat), 64'd23);
        check("ovf_hi", 64'(hi), 64'd0);
        check("ovf_lo", 64'(lo), 64'h8000_0000);
        count_dones(40, nd);
        check("ovf_single_done", 64'(nd), 64'd0);
        check("ovf_idle_after", 64'(busy), 64'd0);

        // MTHI / MTLO while idle
        mthi = 1'b1; wdata = 32'h0000_1234;
        @(negedge clk);
        mthi = 1'b0;
        check("mthi_hi", 64'(hi), 64'h1234);
        check("mthi_lo_kept", 64'(lo), 64'h8000_0000);
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'hABCD_0001;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
        check("mthilo_hi", 64'(hi), 64'hABCD_0001);
        check("mthilo_lo", 64'(lo), 64'hABCD_0001);

        // MTLO while busy is dropped
        l0 = lo;
        op = 2'b01; A = 32'd3; B = 32'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        mtlo = 1'b1; wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        mtlo = 1'b0;
        check("mtlo_busy_ignored", 64'(lo), 64'(l0));
        wait_done(lat);
        check("mtlo_busy_result", 64'(lo), 64'd15);
        @(negedge clk);

        // start together with MTHI: write lands, then the result overwrites it
        op = 2'b01; A = 32'd2; B = 32'd3; start = 1'b1; mthi = 1'b1; wdata = 32'h5555_5555;
        @(negedge clk);
        start = 1'b0; mthi = 1'b0;
        check("start_mthi_hi", 64'(hi), 64'h5555_5555);
        check("start_mthi_busy", 64'(busy), 64'd1);
        wait_done(lat);
        check("start_mthi_res_hi", 64'(hi), 64'd0);
        check("start_mthi_res_lo", 64'(lo), 64'd6);
        @(negedge clk);

        // Reset in the middle of a DIVU
        op = 2'b11; A = 32'd1000; B = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_hi", 64'(hi), 64'd0);
        check("midrst_lo", 64'(lo), 64'd0);
        count_dones(40, nd);
        check("midrst_no_done", 64'(nd), 64'd0);
        run_op(2'b01, 32'd3, 32'd5, lat, nb, held);
        check("midrst_mul_hi", 64'(hi), 64'd0);
        check("midrst_mul_lo", 64'(lo), 64'd15);

        // Randomized operations, launched back-to-back
        for (int i = 0; i < 200; i++) begin
            logic [1:0]  ro;
            logic [31:0] ra;
            logic [31:0] rb;
            int          sel;
            ro  = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) rb = 32'd0;
            if (sel == 1) begin ra = 32'($urandom_range(0, 255)); rb = 32'($urandom_range(1, 15)); end
            if (sel == 2) ra = 32'h8000_0000;
            if (sel == 3) rb = 32'hFFFF_FFFF;
            model(ro, ra, rb, eh, el);
            run_op(ro, ra, rb, lat, nb, held);
            check($sformatf("rnd%0d_lat op=%0d a=%h b=%h", i, ro, ra, rb), 64'(lat), 64'd33);
            check($sformatf("rnd%0d_hi op=%0d a=%h b=%h", i, ro, ra, rb), 64'(hi), 64'(eh));
            check($sformatf("rnd%0d_lo op=%0d a=%h b=%h", i, ro, ra, rb), 64'(lo), 64'(el));
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit for the MIPS pipeline, alongside the combinational ALU in the EX stage. Performs MULT/MULTU/DIV/DIVU over 33 cycles into architectural HI/LO registers, and services MTHI/MTLO writes. EX launches an operation with a one-cycle `start` pulse. Hazard logic stalls any MFHI/MFLO while `busy` is high.

## Interface
Parameters:
- `WIDTH`, 32, operand and HI/LO width; iteration count equals `WIDTH`.

Ports:
- `clk`  in  1  rising-edge clock, the only clock.
- `reset`  in  1  **synchronous, active-high** reset.
- `start`  in  1  launch request; sampled only when idle.
- `op`  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `A`  in  WIDTH  rs operand (multiplicand or dividend).
- `B`  in  WIDTH  rt operand (multiplier or divisor).
- `mthi`  in  1  write `wdata` to HI.
- `mtlo`  in  1  write `wdata` to LO.
- `wdata`  in  WIDTH  MTHI/MTLO data.
- `busy`  out  1  high while an operation is in flight.
- `done`  out  1  one-cycle pulse in the cycle HI/LO first shows a new result.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
- FSM states: IDLE, CALC, FIX. `busy = (state != IDLE)`.
- **IDLE**
  - `start=1`: latch `op`, |A|, |B| and the operand signs. Signed ops take the two's-complement magnitude; unsigned ops use A and B as-is. Clear the iteration counter and go to CALC.
- **CALC**, exactly `WIDTH` cycles, one bit per cycle:
  - Multiply: radix-2 shift-add into a 2·WIDTH accumulator.
  - Divide: restoring shift-subtract. Quotient builds in the low half, partial remainder in the high half.
  - When the counter reaches WIDTH-1, go to FIX.
- **FIX**, one cycle:
  - Sign-correct the result, write HI/LO, pulse `done`, return to IDLE.
  - MULT: negate the 64-bit product if the operand signs differ. HI = upper word, LO = lower word.
  - DIV: LO = quotient, negated if the signs differ. HI = remainder, taking the sign of the dividend.
- **Divide by zero** (B=0), both DIV and DIVU: LO = 0xFFFFFFFF, HI = A. No exception.
- **DIV overflow** (0x80000000 / -1): LO = 0x80000000, HI = 0.
- **MTHI/MTLO**:
  - Honoured only in IDLE; written on the next edge. `mthi` and `mtlo` may be asserted together.
  - Ignored while busy.
  - If `start` and `mthi`/`mtlo` arrive in the same IDLE cycle, the write is performed and the operation is also launched. The operation's result later overwrites the write.
- `start` while busy is ignored and is not queued.
- `hi`/`lo` hold their old values throughout CALC. They change only in FIX or on an MTHI/MTLO write.

## Timing
- **Reset values:** state IDLE, `busy=0`, `done=0`, `hi=0`, `lo=0`, counter 0.
- **Reset mid-operation:** takes effect on the next edge. The operation is abandoned and no `done` is produced.
- **Latency:** `start` sampled at edge k.
  - `busy=1` from after edge k through edge k+33.
  - HI/LO update and `done=1` after edge k+33, i.e. 33 cycles from start to result.
  - `busy` and `done` are never high together.
- **Back-to-back:** the earliest next accepted `start` is the cycle in which `done=1`, since state is IDLE in that cycle.
- **Registered outputs:** all outputs are registered. No combinational path from inputs to outputs.

## Structure
- Shared package `muldiv_pkg` contains:
  - `op` encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU.
  - State encoding: S_IDLE, S_CALC, S_FIX.
  - Constant ITER = WIDTH.
- One sub-module, `sign_fix`, purely combinational:
  - Inputs: raw 2·WIDTH result, operand signs, `op`.
  - Output: corrected {HI, LO}, including the divide-by-zero override.
  - Keeps the FSM/datapath module focused on iteration.

## Test plan
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF → after 33 cycles HI=0xFFFFFFFE, LO=0x00000001. `done` is a single pulse and `busy` was high for 33 cycles.
- MULT A=-7 (0xFFFFFFF9), B=6 → HI=0xFFFFFFFF, LO=0xFFFFFFD6 (-42).
- DIV A=-7, B=2 → LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU A=7, B=0 → LO=0xFFFFFFFF, HI=7.
- DIV A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0. Second `start` pulsed at cycle 10 of the operation → ignored, single `done`.
- MTHI 0x1234 while idle → `hi`=0x1234 next cycle. MTLO during busy → `lo` unchanged until the FIX result lands.
- `reset` asserted at cycle 20 of a DIVU → next cycle `busy=0`, `hi=lo=0`, no `done`. A new MULTU 3×5 then yields LO=15, HI=0.
